// File: rtl/iob_fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of an asynchronous FIFO.
// A burst is granted only when the FIFO level shows room for all of its words.
module iob_fifo_wr_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned BURST_W = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*BURST_W-1:0]   len_i,
    input  logic [N_REQ-1:0]           valid_i,
    input  logic [N_REQ*DATA_W-1:0]    data_i,
    output logic [N_REQ-1:0]           ready_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       busy_o,
    input  logic [ADDR_W:0]            fifo_level_i,
    input  logic                       fifo_full_i,
    output logic                       fifo_w_en_o,
    output logic [DATA_W-1:0]          fifo_w_data_o
);

    localparam int unsigned IDX_W     = $clog2(N_REQ);
    localparam int unsigned LVL_W     = ADDR_W + 1;
    localparam int unsigned CMP_W     = (BURST_W > LVL_W) ? BURST_W : LVL_W;
    localparam int unsigned FIFO_SIZE = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;

    logic [BURST_W-1:0]   len_arr  [N_REQ];
    logic [DATA_W-1:0]    data_arr [N_REQ];
    logic [N_REQ-1:0]     eligible;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign len_arr[i]  = len_i[i*BURST_W +: BURST_W];
        assign data_arr[i] = data_i[i*DATA_W +: DATA_W];
        assign eligible[i] = req_i[i] && (len_i[i*BURST_W +: BURST_W] != '0);
    end

    // First eligible requester searching circularly from rr_ptr_q.
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;
    logic [IDX_W:0]   probe;

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        probe      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            probe = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (probe >= (IDX_W+1)'(N_REQ)) begin
                probe = probe - (IDX_W+1)'(N_REQ);
            end
            if (!cand_found && eligible[probe[IDX_W-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = probe[IDX_W-1:0];
            end
        end
    end

    logic [CMP_W-1:0] free_space;
    logic [CMP_W-1:0] cand_len;
    logic             wr_fire;

    assign free_space = CMP_W'(FIFO_SIZE) - CMP_W'(fifo_level_i);
    assign cand_len   = CMP_W'(len_arr[cand_idx]);
    assign wr_fire    = (state_q == BURST) && valid_i[grant_idx_q] && !fifo_full_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                // No skipping past a candidate that lacks space, so large bursts are not starved.
                if (cand_found && (cand_len <= free_space)) begin
                    state_d     = BURST;
                    grant_idx_d = cand_idx;
                    cnt_d       = len_arr[cand_idx];
                end
            end
            BURST: begin
                if (wr_fire) begin
                    cnt_d = cnt_q - BURST_W'(1);
                    if (cnt_q == BURST_W'(1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_idx_q == IDX_W'(N_REQ-1)) ? '0 : grant_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_o     = '0;
        ready_o     = '0;
        busy_o      = 1'b0;
        fifo_w_en_o = 1'b0;
        if (state_q == BURST) begin
            grant_o[grant_idx_q] = 1'b1;
            ready_o[grant_idx_q] = !fifo_full_i;
            busy_o               = 1'b1;
            fifo_w_en_o          = wr_fire;
        end
    end

    assign fifo_w_data_o = data_arr[grant_idx_q];

endmodule

// File: tb/tb_iob_fifo_wr_arbiter.sv
// Directed bench for iob_fifo_wr_arbiter: N_REQ=2, DATA_W=32, ADDR_W=4, BURST_W=5.
module tb_iob_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [9:0]  len = '0;
    logic [1:0]  valid = '0;
    logic [63:0] data = '0;
    logic [1:0]  ready;
    logic [1:0]  grant;
    logic        busy;
    logic [4:0]  fifo_level = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_w_en;
    logic [31:0] fifo_w_data;

    int total = 0;
    int bad   = 0;
    logic [31:0] wq [$];

    iob_fifo_wr_arbiter #(
        .N_REQ  (2),
        .DATA_W (32),
        .ADDR_W (4),
        .BURST_W(5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .len_i        (len),
        .valid_i      (valid),
        .data_i       (data),
        .ready_o      (ready),
        .grant_o      (grant),
        .busy_o       (busy),
        .fifo_level_i (fifo_level),
        .fifo_full_i  (fifo_full),
        .fifo_w_en_o  (fifo_w_en),
        .fifo_w_data_o(fifo_w_data)
    );

    always #5 clk = ~clk;

    // Words the FIFO would capture on the following rising edge.
    always @(negedge clk) begin
        if (fifo_w_en === 1'b1) wq.push_back(fifo_w_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; len = '0; valid = '0; fifo_level = '0; fifo_full = 1'b0;
        tick();
        rst = 1'b0;
        wq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data = {32'hBBBB_0001, 32'hAAAA_0000};
        #2;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", ready); end
        total++; if (fifo_w_en !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", fifo_w_en); end
        total++; if (fifo_w_data !== 32'hAAAA_0000) begin bad++; $display("FAIL reset_wdata got=%h exp=aaaa0000", fifo_w_data); end
    endtask

    task automatic test_single_burst();
        do_reset();
        req = 2'b01; len = {5'd0, 5'd4}; valid = 2'b01;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_idle_grant got=%b exp=00", grant); end
        for (int i = 0; i < 4; i++) begin
            tick();
            req = 2'b00;
            data[31:0] = 32'hD000_0000 + 32'(i);
            #1;
            total++; if (grant !== 2'b01 || busy !== 1'b1) begin bad++; $display("FAIL single_grant cyc=%0d got=%b/%b exp=01/1", i+1, grant, busy); end
            total++; if (fifo_w_en !== 1'b1 || fifo_w_data !== 32'hD000_0000 + 32'(i)) begin bad++; $display("FAIL single_write cyc=%0d got=%b/%h exp=1/%h", i+1, fifo_w_en, fifo_w_data, 32'hD000_0000 + 32'(i)); end
        end
        tick();
        total++; if (busy !== 1'b0 || grant !== 2'b00 || fifo_w_en !== 1'b0) begin bad++; $display("FAIL single_end got=%b/%b/%b exp=0/00/0", busy, grant, fifo_w_en); end
        total++; if (wq.size() !== 4) begin bad++; $display("FAIL single_count got=%0d exp=4", wq.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++; if (wq[i] !== 32'hD000_0000 + 32'(i)) begin bad++; $display("FAIL single_order idx=%0d got=%h exp=%h", i, wq[i], 32'hD000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                   2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        do_reset();
        req = 2'b11; len = {5'd2, 5'd2}; valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            #1;
            total++; if (grant !== exp_g[c] || ready !== exp_g[c]) begin bad++; $display("FAIL rr cyc=%0d got=%b/%b exp=%b", c, grant, ready, exp_g[c]); end
        end
        req = 2'b00;
        repeat (3) tick();
        total++; if (wq.size() !== 8) begin bad++; $display("FAIL rr_count got=%0d exp=8", wq.size()); end
    endtask

    task automatic test_space_wait();
        do_reset();
        fifo_level = 5'd14; req = 2'b10; len = {5'd3, 5'd0}; valid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (grant !== 2'b00) begin bad++; $display("FAIL space_wait cyc=%0d got=%b exp=00", c, grant); end
        end
        fifo_level = 5'd13;
        tick();
        req = 2'b00;
        #1;
        total++; if (grant !== 2'b10 || fifo_w_en !== 1'b1) begin bad++; $display("FAIL space_grant got=%b/%b exp=10/1", grant, fifo_w_en); end
        repeat (3) tick();
        total++; if (grant !== 2'b00 || wq.size() !== 3) begin bad++; $display("FAIL space_end got=%b/%0d exp=00/3", grant, wq.size()); end
    endtask

    task automatic test_no_skip();
        do_reset();
        fifo_level = 5'd10; req = 2'b11; len = {5'd1, 5'd8}; valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (grant !== 2'b00) begin bad++; $display("FAIL noskip_wait cyc=%0d got=%b exp=00", c, grant); end
        end
        fifo_level = 5'd8;
        for (int c = 0; c < 8; c++) begin
            tick();
            req = 2'b10;
            #1;
            total++; if (grant !== 2'b01) begin bad++; $display("FAIL noskip_burst0 cyc=%0d got=%b exp=01", c, grant); end
        end
        tick();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL noskip_gap got=%b exp=00", grant); end
        tick();
        req = 2'b00;
        #1;
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL noskip_burst1 got=%b exp=10", grant); end
        tick();
        total++; if (grant !== 2'b00 || wq.size() !== 9) begin bad++; $display("FAIL noskip_end got=%b/%0d exp=00/9", grant, wq.size()); end
    endtask

    task automatic test_stalls();
        logic [7:0] v_pat = 8'b1111_1001;
        logic [7:0] f_pat = 8'b0000_1000;
        logic       exp_w, exp_r;
        do_reset();
        req = 2'b01; len = {5'd0, 5'd5}; valid = 2'b01;
        for (int c = 0; c < 8; c++) begin
            tick();
            req = 2'b00;
            len = {5'd0, 5'd1};
            valid = {1'b0, v_pat[c]};
            fifo_full = f_pat[c];
            data[31:0] = 32'h5700_0000 + 32'(c);
            #1;
            exp_r = ~f_pat[c];
            exp_w = v_pat[c] & ~f_pat[c];
            total++; if (grant !== 2'b01 || ready !== {1'b0, exp_r} || fifo_w_en !== exp_w) begin bad++; $display("FAIL stall cyc=%0d got=%b/%b/%b exp=01/%b/%b", c, grant, ready, fifo_w_en, {1'b0, exp_r}, exp_w); end
        end
        fifo_full = 1'b0;
        tick();
        total++; if (grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL stall_end got=%b/%b exp=00/0", grant, busy); end
        total++; if (wq.size() !== 5) begin bad++; $display("FAIL stall_count got=%0d exp=5", wq.size()); end
        else begin
            total++; if (wq[1] !== 32'h5700_0004 || wq[4] !== 32'h5700_0007) begin bad++; $display("FAIL stall_data got=%h,%h exp=57000004,57000007", wq[1], wq[4]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 2'b01; len = {5'd0, 5'd5}; valid = 2'b01;
        tick();
        tick();
        total++; if (fifo_w_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", fifo_w_en, busy); end
        #1 rst = 1'b1;
        #1;
        total++; if (grant !== 2'b00 || busy !== 1'b0 || ready !== 2'b00 || fifo_w_en !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b/%b/%b/%b exp=00/0/00/0", grant, busy, ready, fifo_w_en); end
        req = 2'b11; len = {5'd1, 5'd1}; valid = 2'b11;
        #1 rst = 1'b0;
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rstmid_idle got=%b exp=00", grant); end
        tick();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rstmid_restart got=%b exp=01", grant); end
        req = 2'b00;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_space_wait();
        test_no_skip();
        test_stalls();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
